// File: rtl/servo_ctrl_pkg.sv
// Shared types and constants for the servo motion sequencer.
// State encoding and angle width used by the FSM and slew steps.
package servo_ctrl_pkg;
  localparam int NUM_CH = 4;
  localparam int ANGLE_W = 8;
  localparam int HOME_DEF = 128;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SETTLE
  } state_t;
endpackage

// File: rtl/servo_slew_step.sv
// One channel's bounded step toward its target.
// Purely combinational; saturates at the target, never wraps.
module servo_slew_step
  import servo_ctrl_pkg::*;
(
  input  angle_t angle,
  input  angle_t target,
  input  angle_t step_max,
  output angle_t next_angle,
  output logic   at_target
);
  logic signed [ANGLE_W:0] diff;
  logic [ANGLE_W:0] mag;

  assign diff = $signed({1'b0, target}) - $signed({1'b0, angle});
  assign mag  = diff[ANGLE_W] ? (ANGLE_W+1)'(-diff)
                              : (ANGLE_W+1)'(diff);

  // A full step cannot overshoot: |diff| > step keeps us inside 0..255.
  always_comb begin
    next_angle = target;
    if (mag > {1'b0, step_max}) begin
      if (diff[ANGLE_W]) next_angle = angle - step_max;
      else               next_angle = angle + step_max;
    end
  end

  assign at_target = (next_angle == target);
endmodule

// File: rtl/servo_motion_ctrl.sv
// Frame-paced motion sequencer feeding the 4-channel servo PWM driver.
// Slews each angle by at most STEP_MAX per frame, settles, then pulses done.
module servo_motion_ctrl
  import servo_ctrl_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int FRAME_HZ      = 50,
  parameter int STEP_MAX      = 4,
  parameter int SETTLE_FRAMES = 10,
  parameter int HOME_ANGLE    = HOME_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_angles,
  input  logic        estop,
  output logic [7:0]  angle_0,
  output logic [7:0]  angle_1,
  output logic [7:0]  angle_2,
  output logic [7:0]  angle_3,
  output logic        frame_tick,
  output logic        busy,
  output logic        done
);
  localparam int FC = CLK_FREQ / FRAME_HZ;
  localparam int CW = (FC > 1) ? $clog2(FC) : 1;
  localparam logic [CW-1:0] FC_LAST = CW'(FC - 1);
  localparam angle_t HOME = angle_t'(HOME_ANGLE);
  localparam angle_t STEP = angle_t'(STEP_MAX);
  localparam logic [15:0] SF = 16'(SETTLE_FRAMES);

  state_t state;
  logic [CW-1:0] fcnt;
  logic [15:0] scnt;
  angle_t ang [NUM_CH];
  angle_t tgt [NUM_CH];
  angle_t tgt_eff [NUM_CH];
  angle_t nxt [NUM_CH];
  logic [NUM_CH-1:0] at;

  // estop steers the slew toward home in the same cycle it is seen.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign tgt_eff[i] = estop ? HOME : tgt[i];
    servo_slew_step u_step (
      .angle      (ang[i]),
      .target     (tgt_eff[i]),
      .step_max   (STEP),
      .next_angle (nxt[i]),
      .at_target  (at[i])
    );
  end

  assign frame_tick = (fcnt == FC_LAST);
  assign cmd_ready  = (state == IDLE) && !estop;
  assign busy       = (state != IDLE);
  assign angle_0    = ang[0];
  assign angle_1    = ang[1];
  assign angle_2    = ang[2];
  assign angle_3    = ang[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt  <= '0;
      scnt  <= '0;
      done  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ang[i] <= HOME;
        tgt[i] <= HOME;
      end
    end else begin
      fcnt <= frame_tick ? '0 : fcnt + CW'(1);
      done <= 1'b0;
      if (estop) begin
        state <= MOVE;
        scnt  <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          tgt[i] <= HOME;
          if (frame_tick) ang[i] <= nxt[i];
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (cmd_valid) begin
              state <= MOVE;
              for (int i = 0; i < NUM_CH; i++)
                tgt[i] <= cmd_angles[i*ANGLE_W +: ANGLE_W];
            end
          end
          MOVE: begin
            if (frame_tick) begin
              for (int i = 0; i < NUM_CH; i++)
                ang[i] <= nxt[i];
              if (&at) begin
                scnt <= '0;
                if (SF == 16'd0) begin
                  state <= IDLE;
                  done  <= 1'b1;
                end else begin
                  state <= SETTLE;
                end
              end
            end
          end
          SETTLE: begin
            if (frame_tick) begin
              scnt <= scnt + 16'd1;
              if (scnt + 16'd1 == SF) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Self-checking bench for servo_motion_ctrl: directed table,
// hand sequences for corner cases, randomized run against a model.
module tb_servo_motion_ctrl;
  localparam int FC = 10;
  localparam int STEP = 4;
  localparam int SF = 2;
  localparam int HOME = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [31:0] cmd_angles = '0;
  logic estop = 1'b0;
  logic [7:0] angle_0, angle_1, angle_2, angle_3;
  logic frame_tick, busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  servo_motion_ctrl #(
    .CLK_FREQ(1000), .FRAME_HZ(100), .STEP_MAX(STEP),
    .SETTLE_FRAMES(SF), .HOME_ANGLE(HOME)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_angles(cmd_angles), .estop(estop),
    .angle_0(angle_0), .angle_1(angle_1),
    .angle_2(angle_2), .angle_3(angle_3),
    .frame_tick(frame_tick), .busy(busy), .done(done)
  );

  // Reference model: per-frame slew rules in plain integers
  int m_ang [4];
  int m_tgt [4];
  int m_mode;
  int m_phase;
  int m_wait;
  bit m_done;

  function automatic int toward(input int a, input int t);
    int d;
    d = t - a;
    if (d <= STEP && d >= -STEP) return t;
    return (d > 0) ? a + STEP : a - STEP;
  endfunction

  task automatic model_step();
    bit tick;
    bit all_eq;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_ang[i] = HOME;
        m_tgt[i] = HOME;
      end
      m_mode = 0; m_phase = 0; m_wait = 0; m_done = 0;
    end else begin
      tick = (m_phase == FC - 1);
      m_phase = (m_phase + 1) % FC;
      m_done = 0;
      if (estop) begin
        for (int i = 0; i < 4; i++) begin
          if (tick) m_ang[i] = toward(m_ang[i], HOME);
          m_tgt[i] = HOME;
        end
        m_mode = 1; m_wait = 0;
      end else if (m_mode == 0) begin
        if (cmd_valid) begin
          for (int i = 0; i < 4; i++)
            m_tgt[i] = int'(cmd_angles[8*i +: 8]);
          m_mode = 1;
        end
      end else if (m_mode == 1 && tick) begin
        all_eq = 1;
        for (int i = 0; i < 4; i++) begin
          m_ang[i] = toward(m_ang[i], m_tgt[i]);
          if (m_ang[i] != m_tgt[i]) all_eq = 0;
        end
        if (all_eq) begin
          m_wait = 0;
          if (SF == 0) begin m_mode = 0; m_done = 1; end
          else m_mode = 2;
        end
      end else if (m_mode == 2 && tick) begin
        m_wait++;
        if (m_wait == SF) begin m_mode = 0; m_done = 1; end
      end
    end
  endtask

  always @(posedge clk) model_step();

  function automatic logic [31:0] bus();
    return {angle_3, angle_2, angle_1, angle_0};
  endfunction

  function automatic logic [31:0] pack4(input int a0, a1, a2, a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  task automatic send(input logic [31:0] c);
    cmd_angles = c;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int g = 0;
    while (seen < n && g < (n + 2) * FC) begin
      if (frame_tick) seen++;
      cyc();
      g++;
    end
    if (seen < n) timeout("wait_ticks");
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 2000) begin
      cyc();
      g++;
    end
    if (busy) timeout("wait_idle");
  endtask

  typedef struct {
    logic [31:0] cmd;
    int          ticks;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [6];
  int n;
  int hold;

  initial begin
    vt[0] = '{{8'd253, 8'd2, 8'd253, 8'd2}, 40,
              {8'd253, 8'd2, 8'd253, 8'd2}};
    vt[1] = '{{8'd255, 8'd0, 8'd255, 8'd0}, 1,
              {8'd255, 8'd0, 8'd255, 8'd0}};
    vt[2] = '{{8'd255, 8'd0, 8'd255, 8'd0}, 1,
              {8'd255, 8'd0, 8'd255, 8'd0}};
    vt[3] = '{{8'd128, 8'd128, 8'd128, 8'd128}, 2,
              {8'd247, 8'd8, 8'd247, 8'd8}};
    vt[4] = '{{8'd0, 8'd255, 8'd64, 8'd192}, 5,
              {8'd108, 8'd148, 8'd108, 8'd148}};
    vt[5] = '{{8'd128, 8'd128, 8'd128, 8'd128}, 40,
              {8'd128, 8'd128, 8'd128, 8'd128}};

    // Reset state and first frame_tick position
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("rst_angles", bus(), pack4(128, 128, 128, 128));
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    n = 0;
    while (!frame_tick && n < 100) begin cyc(); n++; end
    chk("first_tick_cycle", 32'(n), 32'd9);

    // Slew with mixed directions and a short step
    done_cnt = 0;
    send({8'd131, 8'd100, 8'd128, 8'd140});
    for (int t = 1; t <= 7; t++) begin
      wait_ticks(1);
      chk($sformatf("slew_t%0d", t), bus(),
          pack4((128 + 4*t > 140) ? 140 : 128 + 4*t, 128, 128 - 4*t, 131));
    end
    chk("slew_settle_busy", 32'(busy), 32'd1);
    wait_ticks(1);
    chk("slew_no_early_done", 32'(done_cnt), 32'd0);
    wait_ticks(1);
    chk("slew_done", 32'(done), 32'd1);
    chk("slew_ready", 32'(cmd_ready), 32'd1);
    cyc();
    chk("slew_done_one", 32'(done_cnt), 32'd1);

    // Table: extremes, same-position command, bulk moves
    foreach (vt[k]) begin
      done_cnt = 0;
      send(vt[k].cmd);
      wait_ticks(vt[k].ticks);
      chk($sformatf("vec%0d_angles", k), bus(), vt[k].exp);
      wait_idle();
      cyc();
      chk($sformatf("vec%0d_done", k), 32'(done_cnt), 32'd1);
    end

    // Busy rejection
    done_cnt = 0;
    send({8'd128, 8'd128, 8'd128, 8'd140});
    cyc();
    chk("rej_ready", 32'(cmd_ready), 32'd0);
    cmd_angles = '0;
    cmd_valid = 1'b1;
    repeat (3) cyc();
    cmd_valid = 1'b0;
    wait_idle();
    cyc();
    chk("rej_angles", bus(), pack4(140, 128, 128, 128));
    chk("rej_done", 32'(done_cnt), 32'd1);

    // Estop mid-move
    send({8'd128, 8'd128, 8'd128, 8'd128});
    wait_idle();
    done_cnt = 0;
    send({8'd128, 8'd128, 8'd128, 8'd200});
    wait_ticks(3);
    chk("es_at140", 32'(angle_0), 32'd140);
    estop = 1'b1;
    wait_ticks(1);
    chk("es_step1", 32'(angle_0), 32'd136);
    chk("es_ready", 32'(cmd_ready), 32'd0);
    wait_ticks(1);
    chk("es_step2", 32'(angle_0), 32'd132);
    chk("es_busy", 32'(busy), 32'd1);
    chk("es_no_done", 32'(done_cnt), 32'd0);
    estop = 1'b0;
    wait_ticks(1);
    chk("es_home", 32'(angle_0), 32'd128);
    wait_idle();
    cyc();
    chk("es_done", 32'(done_cnt), 32'd1);

    // estop and cmd_valid together: command dropped
    done_cnt = 0;
    cmd_angles = {8'd128, 8'd128, 8'd128, 8'd200};
    cmd_valid = 1'b1;
    estop = 1'b1;
    cyc();
    chk("col_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    estop = 1'b0;
    wait_ticks(1);
    chk("col_angles", bus(), pack4(128, 128, 128, 128));
    wait_idle();
    cyc();
    chk("col_done", 32'(done_cnt), 32'd1);

    // Reset mid-move
    send({8'd128, 8'd128, 8'd128, 8'd200});
    wait_ticks(3);
    rst_n = 1'b0;
    cyc();
    chk("rmid_angles", bus(), pack4(128, 128, 128, 128));
    chk("rmid_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) cyc();
    chk("rmid_no_done", 32'(done_cnt), 32'd0);

    // Randomized run against the model
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      chk("rand_angles", bus(),
          pack4(m_ang[0], m_ang[1], m_ang[2], m_ang[3]));
      chk("rand_ctl", {28'd0, cmd_ready, busy, done, frame_tick},
          {28'd0, (m_mode == 0) && !estop, m_mode != 0, m_done,
           m_phase == FC - 1});
      cmd_valid = ($urandom % 4 == 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom % 3 == 0)
          cmd_angles[8*i +: 8] = 8'(m_ang[i] + int'($urandom_range(0, 12)) - 6);
        else
          cmd_angles[8*i +: 8] = 8'($urandom);
      end
      if (hold > 0) begin
        hold--;
        estop = 1'b1;
      end else begin
        estop = 1'b0;
        if ($urandom % 300 == 0) hold = $urandom_range(1, 25);
      end
      rst_n = ($urandom % 1500 != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/servo_motion_ctrl.md
Name: servo_motion_ctrl

Overview:
Motion sequencer between the gesture decoder and the 4-channel servo PWM driver. It accepts a 4-angle target command through a valid/ready handshake and slews each channel's angle toward its target by at most STEP_MAX counts per 20 ms PWM frame. It then waits a settle interval and signals completion. The angle outputs drive the PWM driver's angle_0..3 inputs directly, so servos never see step jumps larger than STEP_MAX per frame.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
FRAME_HZ, 50, slew update rate; FRAME_CYCLES = CLK_FREQ/FRAME_HZ
STEP_MAX, 4, maximum angle change per channel per frame (1..255)
SETTLE_FRAMES, 10, frames held after all channels reach target before done (0 allowed)
HOME_ANGLE, 128, reset/estop angle for all channels (0..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
cmd_valid  in  1  target command valid
cmd_ready  out  1  block can accept a command
cmd_angles  in  32  packed targets; ch0=[7:0], ch1=[15:8], ch2=[23:16], ch3=[31:24]
estop  in  1  synchronous emergency return-to-home, level-sensitive
angle_0..angle_3  out  8 each  current commanded angle per channel, registered
frame_tick  out  1  one-cycle pulse at each frame boundary
busy  out  1  high in MOVE or SETTLE
done  out  1  one-cycle pulse when a motion plus settle completes

Behaviour:
- Reset (rst_n=0 at posedge): angle_0..3=HOME_ANGLE, state=IDLE, frame counter=0, settle counter=0, targets=HOME_ANGLE, frame_tick=0, busy=0, done=0. Reset mid-motion aborts immediately; no completion pulse.
- Frame counter: free-runs 0..FRAME_CYCLES-1 and wraps. frame_tick=1 for the cycle in which the counter equals FRAME_CYCLES-1. Runs in every state; it is not restarted by commands.
- cmd_ready = (state==IDLE) && !estop. This is combinational from state and estop.
- A command is accepted when cmd_valid && cmd_ready at a posedge. Accepting latches cmd_angles into the target registers and moves state to MOVE. Commands presented outside IDLE are ignored and not queued.
- FSM states: IDLE, MOVE, SETTLE.
- IDLE -> MOVE: on command accept or estop.
- MOVE, on each frame_tick, per channel:
  - diff = target - angle, computed as 9-bit signed.
  - If |diff| <= STEP_MAX: angle = target.
  - Else: angle = angle ± STEP_MAX toward target.
  - Results never leave 0..255; no wrap-around.
  - If all four updated angles equal their targets: go to SETTLE and clear the settle counter.
  - A command equal to the current angles reaches SETTLE on the first tick.
- SETTLE: the settle counter increments on each frame_tick. When it reaches SETTLE_FRAMES, go to IDLE with done=1 for exactly one cycle, in the cycle after that tick. With SETTLE_FRAMES=0, done pulses in the cycle after the arrival tick.
- estop (any state, not in reset):
  - Targets := HOME_ANGLE, state := MOVE, settle counter cleared, no done pulse for the aborted motion.
  - While estop is held, the block stays in MOVE slewing home. It reaches SETTLE only after estop is released.
  - Releasing estop then completes the home motion normally, with a done pulse.
  - estop and cmd_valid in the same cycle: estop wins and the command is not accepted.
- Angles change only on frame_tick cycles (and on reset). They are stable for the PWM driver across each frame.
- busy = (state != IDLE).

Decomposition:
- Package servo_ctrl_pkg: state enum (IDLE, MOVE, SETTLE), NUM_CH=4, ANGLE_W=8, default HOME_ANGLE.
- Sub-module servo_slew_step, instantiated 4×: combinational, inputs angle, target and STEP_MAX; outputs next_angle and at_target. The FSM, counters and handshake stay in servo_motion_ctrl.

Test Plan:
All tests use CLK_FREQ=1000, FRAME_HZ=100 (10-cycle frames), STEP_MAX=4, SETTLE_FRAMES=2, HOME_ANGLE=128.
- Reset: hold rst_n=0 for 3 cycles, then release -> angles all 128; cmd_ready=1; busy=0; done=0; frame_tick first pulses at cycle 9 after release.
- Slew: command {ch0=140, ch1=128, ch2=100, ch3=131} ->
  - ch0 steps 132, 136, 140.
  - ch2 steps 124…100 over 7 ticks.
  - ch3 reaches 131 at tick 1; ch1 stays at 128.
  - SETTLE after tick 7; done one cycle after tick 9; cmd_ready=1 again.
- Busy rejection: during MOVE, assert cmd_valid with all targets 0 -> cmd_ready=0, targets unchanged, original motion completes.
- Estop mid-move: from 128, command ch0=200; assert estop after ch0=140, hold 2 frames, release -> ch0 steps 136, 132, 128; no done for the aborted move; done after settle of the home move.
- Extremes: from 253, target 255 -> 255 in one tick. Target 0 from 2 -> 0. No wrap to 1 or 254.
- Reset mid-move and estop/cmd collision:
  - rst_n=0 during MOVE -> angles 128 next cycle, IDLE, no done.
  - estop and cmd_valid asserted together in IDLE -> command dropped, block homes.
